// File: rtl/dbus_pkg.sv
// dbus_pkg: funct3 encodings, MMIO map and lane helpers shared by the data-bus responder.
package dbus_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] OFF_GPIO_OUT  = 5'h00;
    localparam logic [4:0] OFF_GPIO_IN   = 5'h04;
    localparam logic [4:0] OFF_MTIME     = 5'h08;
    localparam logic [4:0] OFF_TIMER_CMP = 5'h0C;
    localparam logic [4:0] OFF_STATUS    = 5'h10;

    localparam int ST_TIMER_HIT = 0;
    localparam int ST_MISALIGN  = 1;

    // Misaligned halfwords keep addr[1]; misaligned words cover the whole word.
    function automatic logic [3:0] byte_en(logic [2:0] st, logic [1:0] a);
        return st == F3_SB ? 4'b0001 << a :
               st == F3_SH ? (a[1] ? 4'b1100 : 4'b0011) :
               st == F3_SW ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] store_data(logic [2:0] st, logic [31:0] d);
        return st == F3_SB ? {4{d[7:0]}} : st == F3_SH ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] merge_be(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    function automatic logic misaligned(logic we, logic [2:0] st, logic [2:0] lt, logic [1:0] a);
        return we ? ((st == F3_SH && a[0]) || (st == F3_SW && a != 2'b00))
                  : (((lt == F3_LH || lt == F3_LHU) && a[0]) || (lt == F3_LW && a != 2'b00));
    endfunction

    function automatic logic [31:0] load_extend(logic [31:0] w, logic [2:0] lt, logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        return lt == F3_LB  ? {{24{b[7]}}, b} :
               lt == F3_LBU ? {24'd0, b} :
               lt == F3_LH  ? {{16{h[15]}}, h} :
               lt == F3_LHU ? {16'd0, h} : w;
    endfunction

endpackage

// File: rtl/dbus_mmio_regs.sv
// dbus_mmio_regs: GPIO out, synchronised GPIO in, free-running MTIME, compare timer
// and the sticky write-1-to-clear STATUS register.
module dbus_mmio_regs
    import dbus_pkg::*;
#(
    parameter int GPIO_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [2:0]        sel_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    input  logic              misalign_i,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [31:0]       rdata_o,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic              timer_irq_o
);

    logic [GPIO_W-1:0] gpio_q, gpio_d, sync1_q, sync2_q;
    logic [31:0]       mtime_q, cmp_q, cmp_d;
    logic [1:0]        status_q, status_d, clr, set;

    always_comb begin
        gpio_d = (we_i && sel_i == OFF_GPIO_OUT[4:2]) ? GPIO_W'(merge_be(32'(gpio_q), wdata_i, be_i)) : gpio_q;
        cmp_d = (we_i && sel_i == OFF_TIMER_CMP[4:2]) ? merge_be(cmp_q, wdata_i, be_i) : cmp_q;
        clr = (we_i && sel_i == OFF_STATUS[4:2] && be_i[0]) ? wdata_i[1:0] : 2'b00;
        set[ST_TIMER_HIT] = mtime_q == cmp_q && cmp_q != 32'd0;
        set[ST_MISALIGN] = misalign_i;
        // Set is applied after clear so a coincident event keeps the bit.
        status_d = (status_q & ~clr) | set;
        rdata_o = sel_i == OFF_GPIO_OUT[4:2]  ? 32'(gpio_q) :
                  sel_i == OFF_GPIO_IN[4:2]   ? 32'(sync2_q) :
                  sel_i == OFF_MTIME[4:2]     ? mtime_q :
                  sel_i == OFF_TIMER_CMP[4:2] ? cmp_q :
                  sel_i == OFF_STATUS[4:2]    ? 32'(status_q) : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            mtime_q  <= '0;
            cmp_q    <= '0;
            status_q <= '0;
        end else begin
            gpio_q   <= gpio_d;
            sync1_q  <= gpio_in_i;
            sync2_q  <= sync1_q;
            mtime_q  <= mtime_q + 32'd1;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    assign gpio_out_o  = gpio_q;
    assign timer_irq_o = status_q[ST_TIMER_HIT];

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: CPU data-port responder with a byte-lane data RAM and an MMIO bank;
// loads return combinationally, stores commit on the clock edge.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write_en,
    input  logic [2:0]        s_type,
    input  logic [2:0]        l_type,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]   mem [DEPTH];
    logic          ram_sel, mmio_sel, misalign;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata, mmio_rdata, word;

    always_comb begin
        ram_sel = mem_addr < RAM_BYTES;
        mmio_sel = mem_addr[31:5] == MMIO_BASE[31:5];
        idx = mem_addr[AW+1:2];
        be = byte_en(s_type, mem_addr[1:0]);
        wdata = store_data(s_type, mem_wdata);
        misalign = misaligned(mem_write_en, s_type, l_type, mem_addr[1:0]);
        word = ram_sel ? mem[idx] : mmio_sel ? mmio_rdata : 32'd0;
        mem_rdata = load_extend(word, l_type, mem_addr[1:0]);
    end

    // RAM contents survive reset, but stores are held off while it is asserted.
    always_ff @(posedge clk) begin
        if (reset && mem_write_en && ram_sel)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    dbus_mmio_regs #(
        .GPIO_W(GPIO_W)
    ) u_mmio (
        .clk_i      (clk),
        .rst_ni     (reset),
        .we_i       (mem_write_en && mmio_sel),
        .sel_i      (mem_addr[4:2]),
        .be_i       (be),
        .wdata_i    (wdata),
        .misalign_i (misalign),
        .gpio_in_i  (gpio_in),
        .rdata_o    (mmio_rdata),
        .gpio_out_o (gpio_out),
        .timer_irq_o(timer_irq)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed plan followed by random traffic, all checked against a
// byte-addressed reference model of RAM and MMIO kept in the bench.
module tb_dbus_responder;

    localparam int          DEPTH     = 256;
    localparam int          GPIO_W    = 8;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
    localparam logic [31:0] A_GOUT    = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_GIN     = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_MT      = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_CMP     = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_STAT    = MMIO_BASE + 32'h10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_write_en = 1'b0;
    logic [2:0]        s_type = 3'd2;
    logic [2:0]        l_type = 3'd2;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic [GPIO_W-1:0] gpio_in = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  ram_m [DEPTH*4];
    logic [31:0] mtime_m, cmp_m;
    logic [7:0]  gpio_m, s1_m, s2_m;
    logic [1:0]  st_m;

    always #5 clk = ~clk;

    dbus_responder #(
        .DEPTH(DEPTH), .GPIO_W(GPIO_W), .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk(clk), .reset(reset), .mem_write_en(mem_write_en), .s_type(s_type),
        .l_type(l_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sw_width(input logic [2:0] st);
        return st == 3'd0 ? 1 : st == 3'd1 ? 2 : st == 3'd2 ? 4 : 0;
    endfunction

    function automatic int ld_width(input logic [2:0] lt);
        return (lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : lt == 3'd2 ? 4 : 0;
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] a, w;
        logic [7:0]  b;
        logic [15:0] h;
        a = {mem_addr[31:2], 2'b00};
        w = '0;
        if (a < DEPTH * 4) w = {ram_m[a+3], ram_m[a+2], ram_m[a+1], ram_m[a]};
        else if (a[31:5] == MMIO_BASE[31:5])
            case (a[4:2])
                3'd0: w = 32'(gpio_m);
                3'd1: w = 32'(s2_m);
                3'd2: w = mtime_m;
                3'd3: w = cmp_m;
                3'd4: w = 32'(st_m);
                default: w = '0;
            endcase
        b = w[8*mem_addr[1:0] +: 8];
        h = w[16*mem_addr[1] +: 16];
        case (l_type)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'd0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Advance one clock edge, updating the model from the inputs present before it.
    task automatic step();
        logic        live;
        logic [7:0]  g, gin;
        logic [31:0] c, ba;
        logic [1:0]  clr, set;
        int          w;
        live = reset;
        g = gpio_m;
        c = cmp_m;
        gin = gpio_in;
        clr = 2'b00;
        set = 2'b00;
        if (live) begin
            set[0] = mtime_m == cmp_m && cmp_m != 0;
            w = mem_write_en ? sw_width(s_type) : ld_width(l_type);
            set[1] = w > 0 && (mem_addr % w) != 0;
            if (mem_write_en)
                for (int k = 0; k < sw_width(s_type); k++) begin
                    ba = (mem_addr & ~32'(sw_width(s_type) - 1)) + 32'(k);
                    if (ba < DEPTH * 4) ram_m[ba] = mem_wdata[8*k +: 8];
                    else if (ba[31:5] == MMIO_BASE[31:5]) begin
                        if (ba[4:0] == 5'h00) g = mem_wdata[8*k +: 8];
                        if (ba[4:2] == 3'd3) c[8*ba[1:0] +: 8] = mem_wdata[8*k +: 8];
                        if (ba[4:0] == 5'h10) clr = mem_wdata[8*k +: 2];
                    end
                end
        end
        @(posedge clk);
        if (live) begin
            st_m = (st_m & ~clr) | set;
            mtime_m = mtime_m + 1;
            s2_m = s1_m;
            s1_m = gin;
            gpio_m = g;
            cmp_m = c;
        end
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] st, input logic [31:0] d);
        mem_write_en = 1'b1;
        s_type = st;
        mem_addr = a;
        mem_wdata = d;
        step();
        mem_write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] lt, input logic [31:0] exp, input string tag);
        mem_write_en = 1'b0;
        mem_addr = a;
        l_type = lt;
        #1;
        check(tag, mem_rdata, exp);
    endtask

    task automatic model_reset();
        mtime_m = '0;
        cmp_m = '0;
        gpio_m = '0;
        s1_m = '0;
        s2_m = '0;
        st_m = '0;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < DEPTH * 4; i++) ram_m[i] = '0;
        #1 reset = 1'b0;
        #11;
        check("rst_gpio_out", 32'(gpio_out), 0);
        check("rst_irq", 32'(timer_irq), 0);
        rd(A_MT, 3'd2, 0, "rst_mtime");
        reset = 1'b1;
        step();
        for (int i = 0; i < 16; i++) wr(32'(4 * i), 3'd2, 0);

        wr(32'h10, 3'd2, 32'hDEADBEEF);
        rd(32'h10, 3'd2, 32'hDEADBEEF, "lw");
        rd(32'h10, 3'd0, 32'hFFFFFFEF, "lb");
        rd(32'h13, 3'd4, 32'h000000DE, "lbu");
        rd(32'h12, 3'd1, 32'hFFFFDEAD, "lh");
        rd(32'h10, 3'd5, 32'h0000BEEF, "lhu");
        wr(32'h20, 3'd2, 32'hAABBCCDD);
        wr(32'h21, 3'd0, 32'h12);
        rd(32'h20, 3'd2, 32'hAABB12DD, "sb_lane");
        wr(32'h22, 3'd1, 32'h5566);
        rd(32'h20, 3'd2, 32'h556612DD, "sh_lane");

        wr(A_GOUT, 3'd2, 32'hA5);
        check("gpio_out", 32'(gpio_out), 32'hA5);
        rd(A_GOUT, 3'd2, 32'hA5, "gpio_out_rd");
        gpio_in = 8'h3C;
        rd(A_GIN, 3'd2, 0, "gpio_in_0");
        step();
        rd(A_GIN, 3'd2, 0, "gpio_in_1");
        step();
        rd(A_GIN, 3'd2, 32'h3C, "gpio_in_2");

        wr(A_CMP, 3'd2, mtime_m + 5);
        check("irq_edge1", 32'(timer_irq), 0);
        for (int i = 2; i <= 5; i++) begin
            step();
            check("irq_early", 32'(timer_irq), 0);
        end
        step();
        check("irq_edge6", 32'(timer_irq), 1);
        wr(A_STAT, 3'd2, 1);
        check("irq_w1c", 32'(timer_irq), 0);
        wr(A_CMP, 3'd2, mtime_m + 2);
        step();
        check("irq_pre_tie", 32'(timer_irq), 0);
        wr(A_STAT, 3'd2, 1);
        check("irq_set_wins", 32'(timer_irq), 1);
        wr(A_CMP, 3'd2, 0);
        wr(A_STAT, 3'd2, 3);
        check("irq_cleared", 32'(timer_irq), 0);

        rd(32'h12, 3'd2, 32'hDEADBEEF, "lw_misalign");
        step();
        rd(A_STAT, 3'd2, 2, "misalign_load");
        wr(A_STAT, 3'd2, 2);
        wr(32'h23, 3'd1, 32'h7788);
        rd(32'h20, 3'd2, 32'h778812DD, "sh_misalign");
        rd(A_STAT, 3'd2, 2, "misalign_store");
        wr(A_STAT, 3'd2, 2);
        rd(A_STAT, 3'd2, 0, "status_clear");

        wr(32'h4000, 3'd2, 32'hFFFFFFFF);
        rd(32'h4000, 3'd2, 0, "unmapped_rd");
        rd(32'h0, 3'd2, 0, "unmapped_ram");
        rd(A_GOUT, 3'd2, 32'hA5, "unmapped_gpio");

        wr(A_GOUT, 3'd2, 32'hFF);
        wr(A_CMP, 3'd2, 32'hFFFF0000);
        while (mtime_m < 100) step();
        rd(32'h12, 3'd2, 32'hDEADBEEF, "pre_rst_rd");
        step();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_gpio", 32'(gpio_out), 0);
        check("rst_irq2", 32'(timer_irq), 0);
        rd(A_GOUT, 3'd2, 0, "rst_rd_gout");
        rd(A_GIN, 3'd2, 0, "rst_rd_gin");
        rd(A_MT, 3'd2, 0, "rst_rd_mtime");
        rd(A_CMP, 3'd2, 0, "rst_rd_cmp");
        rd(A_STAT, 3'd2, 0, "rst_rd_stat");
        wr(32'h10, 3'd2, 32'h12345678);
        wr(A_GOUT, 3'd2, 32'h77);
        check("rst_store_gpio", 32'(gpio_out), 0);
        rd(32'h10, 3'd2, 32'hDEADBEEF, "rst_store_ram");
        rd(A_MT, 3'd2, 0, "rst_mtime_hold");
        reset = 1'b1;
        step();
        rd(A_MT, 3'd2, 1, "mtime_release");

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 3);
            mem_write_en = $urandom_range(0, 2) == 0;
            s_type = r == 3 ? 3'($urandom_range(3, 7)) : 3'(r);
            l_type = 3'($urandom);
            r = $urandom_range(0, 19);
            mem_addr = r == 0 ? 32'h4000 + 32'($urandom_range(0, 63)) :
                       r < 4  ? MMIO_BASE + 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 63));
            mem_wdata = $urandom;
            gpio_in = 8'($urandom);
            #1;
            check("rnd_rdata", mem_rdata, exp_rd());
            check("rnd_gpio", 32'(gpio_out), 32'(gpio_m));
            check("rnd_irq", 32'(timer_irq), 32'(st_m[0]));
            step();
        end
        mem_write_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
